// File: rtl/mux8_pkg.sv
// ---------------------------------------------------------------------------
// mux8_pkg
// Shared definitions for the eight-way round-robin bus arbiter:
//   - bus geometry (requester count, select width, data width, burst counter)
//   - legal MAXBURST range
//   - FSM state type
//   - rr_pick8: combinational round-robin search returning {found, index}
// ---------------------------------------------------------------------------
package mux8_pkg;

    localparam int NREQ = 8;    // number of requesters
    localparam int SELW = 3;    // select / pointer width
    localparam int DW   = 32;   // data word width
    localparam int CNTW = 4;    // beat counter width within one grant

    localparam int MAXBURST_MIN = 1;
    localparam int MAXBURST_MAX = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic            found;
        logic [SELW-1:0] idx;
    } pick_t;

    // Search req starting at ptr, moving upward and wrapping 7 -> 0.
    // The first set bit wins. The index arithmetic is deliberately SELW bits
    // wide so the wrap happens for free.
    function automatic pick_t rr_pick8(input logic [NREQ-1:0] req,
                                       input logic [SELW-1:0] ptr);
        pick_t           res;
        logic [SELW-1:0] idx;
        res.found = 1'b0;
        res.idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + SELW'(k);
            if (!res.found && req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

    // One-hot decode of a requester index into a grant vector.
    function automatic logic [NREQ-1:0] onehot8(input logic [SELW-1:0] idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_mux.sv
// ---------------------------------------------------------------------------
// MUX8T1_32
// Plain 8:1 multiplexer for 32-bit words. Purely combinational.
// Ports:
//   I0..I7  in  32  input words
//   s       in  3   select
//   o       out 32  selected word, o = I[s]
// ---------------------------------------------------------------------------
module MUX8T1_32
    import mux8_pkg::*;
(
    input  logic [DW-1:0]   I0,
    input  logic [DW-1:0]   I1,
    input  logic [DW-1:0]   I2,
    input  logic [DW-1:0]   I3,
    input  logic [DW-1:0]   I4,
    input  logic [DW-1:0]   I5,
    input  logic [DW-1:0]   I6,
    input  logic [DW-1:0]   I7,
    input  logic [SELW-1:0] s,
    output logic [DW-1:0]   o
);

    always_comb begin
        o = I0;
        case (s)
            3'd0:    o = I0;
            3'd1:    o = I1;
            3'd2:    o = I2;
            3'd3:    o = I3;
            3'd4:    o = I4;
            3'd5:    o = I5;
            3'd6:    o = I6;
            3'd7:    o = I7;
            default: o = I0;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter sharing one 32-bit bus among eight requesters. It owns
// the select of an 8:1 mux and presents the selected word to one consumer
// over valid/ready. A granted requester keeps the bus for at most MAXBURST
// accepted beats, or until it drops its request, then the grant rotates.
// Exactly one IDLE cycle separates consecutive grants.
//
// Parameters:
//   MAXBURST  maximum accepted beats per grant (1..16)
// Ports:
//   clk       in  1   system clock
//   rst       in  1   synchronous active-high reset
//   req       in  8   request vector, req[i] held while requester i has data
//   I0..I7    in  32  requester data words
//   o_ready   in  1   consumer accepts a beat this cycle
//   o_valid   out 1   o carries a valid beat
//   o         out 32  selected word, I[s]
//   s         out 3   registered select
//   gnt       out 8   registered one-hot grant, zero when idle
//   ack       out 8   one-hot pulse on the cycle a beat from i is accepted
// ---------------------------------------------------------------------------
module mux8_rr_arbiter
    import mux8_pkg::*;
#(
    parameter int MAXBURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [DW-1:0]   I0,
    input  logic [DW-1:0]   I1,
    input  logic [DW-1:0]   I2,
    input  logic [DW-1:0]   I3,
    input  logic [DW-1:0]   I4,
    input  logic [DW-1:0]   I5,
    input  logic [DW-1:0]   I6,
    input  logic [DW-1:0]   I7,
    input  logic            o_ready,
    output logic            o_valid,
    output logic [DW-1:0]   o,
    output logic [SELW-1:0] s,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] ack
);

    // An out-of-range burst length would silently alias in the 4-bit counter,
    // so refuse to elaborate instead.
    if (MAXBURST < MAXBURST_MIN || MAXBURST > MAXBURST_MAX) begin : g_bad_maxburst
        $error("mux8_rr_arbiter: MAXBURST must be within 1..16");
    end

    // Counter value at which the next accepted beat is the last of the burst.
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(MAXBURST - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_next;
    logic [SELW-1:0] r_s;
    logic [SELW-1:0] w_s_next;
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_ptr_next;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_next;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_next;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    pick_t           w_pick;
    logic            w_in_grant;
    logic            w_req_sel;
    logic            w_valid;
    logic            w_accept;
    logic            w_last_beat;
    logic            w_grant_end;
    logic [DW-1:0]   w_mux_o;

    assign w_pick     = rr_pick8(req, r_ptr);
    assign w_in_grant = (r_state == ST_GRANT);
    assign w_req_sel  = req[r_s];

    // A requester dropping its request the same cycle deasserts valid at
    // once, so a withdrawal can never coincide with an accept.
    assign w_valid     = w_in_grant & w_req_sel;
    assign w_accept    = w_valid & o_ready;
    assign w_last_beat = (r_cnt == LAST_BEAT);
    assign w_grant_end = w_in_grant & (~w_req_sel | (w_accept & w_last_beat));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_ptr   <= w_ptr_next;
            r_gnt   <= w_gnt_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_ptr_next   = r_ptr;
        w_gnt_next   = r_gnt;
        w_cnt_next   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                // req bits that rose during the previous grant are only
                // considered here, never mid-grant.
                if (w_pick.found) begin
                    w_state_next = ST_GRANT;
                    w_s_next     = w_pick.idx;
                    w_gnt_next   = onehot8(w_pick.idx);
                    w_cnt_next   = '0;
                end
            end
            ST_GRANT: begin
                if (w_grant_end) begin
                    // s is left alone so o stays stable through the bubble;
                    // the search restarts just above the departing requester.
                    w_state_next = ST_IDLE;
                    w_ptr_next   = r_s + SELW'(1);
                    w_gnt_next   = '0;
                end else if (w_accept) begin
                    w_cnt_next = r_cnt + CNTW'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
        assign ack[gi] = r_gnt[gi] & w_accept;
    end

    MUX8T1_32 u_mux (
        .I0 (I0),
        .I1 (I1),
        .I2 (I2),
        .I3 (I3),
        .I4 (I4),
        .I5 (I5),
        .I6 (I6),
        .I7 (I7),
        .s  (r_s),
        .o  (w_mux_o)
    );

    assign o       = w_mux_o;
    assign o_valid = w_valid;
    assign s       = r_s;
    assign gnt     = r_gnt;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux8_rr_arbiter
// Directed bench for mux8_rr_arbiter with MAXBURST = 4. Inputs change just
// after the rising edge; outputs are sampled a few ns later, well away from
// the next edge.
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [31:0] din [8];
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o;
    logic [2:0]  s;
    logic [7:0]  gnt;
    logic [7:0]  ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAXBURST(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .I0      (din[0]),
        .I1      (din[1]),
        .I2      (din[2]),
        .I3      (din[3]),
        .I4      (din[4]),
        .I5      (din[5]),
        .I6      (din[6]),
        .I7      (din[7]),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o       (o),
        .s       (s),
        .gnt     (gnt),
        .ack     (ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected word of requester i, written out by hand.
    function automatic logic [31:0] word_of(input int i);
        case (i)
            0:       return 32'hAA550000;
            1:       return 32'h55AA1111;
            2:       return 32'h55AA2222;
            3:       return 32'h55AA3333;
            4:       return 32'h55AA4444;
            5:       return 32'h55AA5555;
            6:       return 32'h55AA6666;
            default: return 32'h55AA7777;
        endcase
    endfunction

    // Expects a grant to idx with o_ready high; checks nbeats accepted beats.
    task automatic run_burst(input string tag, input int idx, input int nbeats);
        logic [7:0] oh;
        oh = 8'h01 << idx;
        for (int b = 0; b < nbeats; b++) begin
            $display("beat %s: req=%02h s=%0d gnt=%02h ack=%02h o=%08h", tag, req, s, gnt, ack, o);
            chk({tag, "_s"},     32'(s),       32'(idx));
            chk({tag, "_gnt"},   32'(gnt),     32'(oh));
            chk({tag, "_valid"}, 32'(o_valid), 32'd1);
            chk({tag, "_ack"},   32'(ack),     32'(oh));
            chk({tag, "_o"},     o,            word_of(idx));
            step();
        end
    endtask

    task automatic check_idle(input string tag);
        $display("idle %s: req=%02h s=%0d gnt=%02h ack=%02h", tag, req, s, gnt, ack);
        chk({tag, "_gnt"},   32'(gnt),     32'd0);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_ack"},   32'(ack),     32'd0);
    endtask

    initial begin
        logic bp [6];
        int   acks;
        bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst     = 1'b1;
        req     = 8'hFF;
        o_ready = 1'b1;
        din[0]  = 32'hAA550000;
        din[1]  = 32'h55AA1111;
        din[2]  = 32'h55AA2222;
        din[3]  = 32'h55AA3333;
        din[4]  = 32'h55AA4444;
        din[5]  = 32'h55AA5555;
        din[6]  = 32'h55AA6666;
        din[7]  = 32'h55AA7777;

        // Reset held for three edges with every requester asking.
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("reset");
            chk("reset_s", 32'(s), 32'd0);
        end
        rst = 1'b0;
        #1;
        check_idle("post_reset");
        step();

        // Full rotation 0..7,0 with four beats each and a bubble in between.
        for (int g = 0; g < 9; g++) begin
            run_burst("rot", g % 8, 4);
            check_idle("rot_bubble");
            chk("rot_bubble_s", 32'(s), 32'(g % 8));
            if (g != 8) step();
        end

        // Backpressure on a lone requester 3 (ptr is 1 here).
        req = 8'h08;
        #1;
        step();
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            o_ready = bp[k];
            #1;
            $display("bp: ready=%0d s=%0d gnt=%02h ack=%02h o=%08h", o_ready, s, gnt, ack, o);
            chk("bp_s",     32'(s),       32'd3);
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_o",     o,            32'h55AA3333);
            chk("bp_ack",   32'(ack),     bp[k] ? 32'h08 : 32'h00);
            if (ack[3]) acks++;
            step();
        end
        chk("bp_ack_count", 32'(acks), 32'd4);
        check_idle("bp_end");

        // ptr should now be 4: with 3 and 5 requesting, 5 must win.
        req     = 8'h2A;
        o_ready = 1'b1;
        #1;
        step();
        run_burst("wd", 5, 2);
        req = 8'h0A;
        #1;
        $display("withdraw: req=%02h s=%0d gnt=%02h ack=%02h valid=%0d", req, s, gnt, ack, o_valid);
        chk("wd_valid", 32'(o_valid), 32'd0);
        chk("wd_ack",   32'(ack),     32'd0);
        chk("wd_gnt",   32'(gnt),     32'h20);
        step();
        check_idle("wd_idle");
        step();
        // Search restarts at 6 and wraps to the lowest remaining bit, 1.
        chk("wd_next_s",   32'(s),   32'd1);
        chk("wd_next_gnt", 32'(gnt), 32'h02);

        // Withdraw 1 at once, then give requester 6 a full burst so ptr = 7.
        req = 8'h40;
        #1;
        chk("wd1_valid", 32'(o_valid), 32'd0);
        step();
        check_idle("wd1_idle");
        step();
        run_burst("g6", 6, 4);
        check_idle("g6_bubble");

        // Sparse requests from ptr 7: 1 then 2, then nothing.
        req = 8'h06;
        #1;
        step();
        run_burst("wrap1", 1, 4);
        check_idle("wrap1_bubble");
        step();
        run_burst("wrap2", 2, 4);
        req = 8'h00;
        #1;
        check_idle("wrap_end");
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("no_req");
        end

        // Reset during beat 2 of a grant to requester 6 (ptr is 3 here).
        req = 8'h40;
        #1;
        step();
        run_burst("rmb", 6, 1);
        rst = 1'b1;
        #1;
        chk("rmb_beat2_valid", 32'(o_valid), 32'd1);
        chk("rmb_beat2_o",     o,            32'h55AA6666);
        step();
        rst = 1'b0;
        #1;
        check_idle("rmb_after");
        chk("rmb_after_s", 32'(s), 32'd0);
        // ptr must be 0 again: with 1 and 6 requesting, 1 wins (6 would win from 3).
        req = 8'h42;
        #1;
        step();
        run_burst("rmb_next", 1, 4);
        check_idle("rmb_next_bubble");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on simulation time in case the sequence above stalls.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 32-bit output bus between eight requesters. It drives the 3-bit select of an 8:1 × 32-bit multiplexer and presents the selected word to a single consumer over a valid/ready handshake. Each granted requester keeps the bus for a bounded burst before the grant rotates. It sits between the eight data sources and the `MUX8T1_32` datapath, and replaces the free-running or testbench-driven `s` counter.

## Interface
- `MAXBURST`, default 4: maximum accepted beats per grant; legal range 1–16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request vector; `req[i]` held high while requester i has data on `Ii`.
- `I0`…`I7`  in  32 each  requester data words.
- `o_ready`  in  1  consumer can accept a beat this cycle.
- `o_valid`  out  1  `o` carries a valid beat.
- `o`  out  32  selected data word, equal to `I[s]`.
- `s`  out  3  current select, registered.
- `gnt`  out  8  one-hot grant, registered; all zero when idle.
- `ack`  out  8  one-hot, single-cycle pulse on the cycle a beat from requester i is accepted.

## Operation
- States: IDLE and GRANT, with 1-bit encoding.
- **Arbitration (IDLE):**
  - Search `req` starting at index `ptr` and moving upward modulo 8. The first set bit is the winner w.
  - If `req` == 0, stay in IDLE.
  - Otherwise go to GRANT with `s`←w, `gnt`←1<<w, `cnt`←0.
- **Outputs:**
  - `o_valid` = (state==GRANT) & `req[s]`, combinational.
  - `o` = mux(`s`), combinational.
  - `ack` = `gnt` & {8{`o_valid` & `o_ready`}}.
- **Accept:** a beat is accepted when `o_valid` & `o_ready`. On accept, `cnt`←`cnt`+1.
- **Grant end:** the grant ends in GRANT when either condition holds:
  - (a) an accept occurs with `cnt`==`MAXBURST`-1;
  - (b) `req[s]`==0, meaning the requester withdrew.

  On grant end:
  - `ptr`←(`s`+1) mod 8, wrapping 7→0;
  - `gnt`←0;
  - state←IDLE.
  - `s` holds its value.
- **Stall:** `o_ready`=0 while `o_valid`=1 holds state, `cnt` and `s`. The beat stays presented and is not dropped.
- **Width rules:**
  - `cnt` is 4 bits.
  - `ptr` and `s` are 3 bits and wrap naturally.
  - Data is passed through unmodified; there is no arithmetic on data.
- **Fairness:** a requester holding `req` continuously is granted within 7 grants of other requesters.
- **Simultaneous events:**
  - The same-cycle `req[s]` drop during GRANT deasserts `o_valid` that cycle, so no accept occurs and the grant ends.
  - A new `req` bit rising during GRANT has no effect until the next IDLE.

## Timing
- **Reset:** state=IDLE, `s`=0, `gnt`=0, `ptr`=0, `cnt`=0, `o_valid`=0, `ack`=0. `o` shows `I0`, but it is unqualified.
- **Reset mid-burst:** reset on any cycle aborts the grant at the next edge. No `ack` is produced in the reset cycle's successor; `ack` is combinational and is 0 once state=IDLE.
- **Latency:** `req` sampled high at edge n in IDLE → `gnt` and `s` valid after edge n, so `o_valid` can be high in cycle n+1.
- **Bubble:** exactly one IDLE cycle separates consecutive grants.
- **Throughput:**
  - With `o_ready` tied high and all requesters busy, the bus carries `MAXBURST` beats per `MAXBURST`+1 cycles.
  - With `MAXBURST`=1, this is 1 beat every 2 cycles.
- **Data hold:** `o` and `s` are stable throughout a grant. Requesters must hold `Ii` stable until they see `ack[i]`.

## Structure
- **Package `mux8_pkg`:**
  - `NREQ`=8, `SELW`=3, `DW`=32;
  - state typedef/localparams `ST_IDLE`, `ST_GRANT`;
  - `MAXBURST` range limit.
- **Sub-module:** instantiate the existing `MUX8T1_32` for the datapath, with ports `I0`…`I7`, `s` and `o`.
- **Round-robin picker:** a combinational function `rr_pick8(req, ptr)` returning {found, index}, kept in the package.
- **Top:** the FSM, `ptr`, `cnt` and the output decode live in the top; there are no other sub-modules.

## Test plan
- **Reset:** hold `rst` for 3 cycles with `req`=8'hFF → `gnt`=0, `o_valid`=0, `s`=0, `ack`=0 throughout. After release, the first `gnt`=8'h01.
- **Round-robin rotation:**
  - Stimulus: `I0`…`I7` = 32'hAA550000, 32'h55AA1111, …, 32'h55AA7777; `req`=8'hFF; `o_ready`=1; `MAXBURST`=4.
  - Required: `s` sequence 0,1,…,7,0. Each grant has 4 beats with `o` equal to that requester's word, and a 1-cycle bubble between grants.
- **Backpressure:** single `req[3]`; drive `o_ready` in the pattern 1,0,0,1,1,1 → exactly 4 `ack[3]` pulses; `o`=32'h55AA3333 is held during the stall cycles. Then the grant ends and `ptr`=4.
- **Withdrawal:** `req[5]` drops after 2 accepted beats → `o_valid`=0 that cycle, then IDLE. The next winner is the lowest set `req` bit at or above index 6, wrapping.
- **Wrap and sparse requests:** `ptr`=7 with `req`=8'b0000_0110 → the grant goes to 1, then 2, then IDLE. `gnt`=0 while `req`=0.
- **Reset mid-burst:** assert `rst` during beat 2 of a grant to requester 6 → state is IDLE at the next edge, with `ptr`=0, `cnt`=0 and no further `ack`.
